led_mode_scheduler: RTL and testbench
=====================================

# led_mode_scheduler

Top-level sequencer for the LED driver's pattern modes. It owns the per-mode enables (`MODE_ON`), so exactly one pattern-mode block runs at a time. It advances between modes on a user request or automatically after a mode completes a set number of pattern loops, and multiplexes the selected mode's LED vector onto the board outputs. It sits between the clock divider (`PULSE`) and the mode1–mode4 blocks.

## Interface
Parameters:
- `BLANK_CYCLES`, default 2: `PULSE` cycles with all modes disabled and LEDs dark between modes; legal range 1–15.
- `LOOPS_PER_MODE`, default 3: completed pattern loops before auto-advance; legal range 1–15.

Ports:
- `PULSE` in 1: divided clock. All logic is clocked on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `BTN_NEXT` in 1: advance request, sampled each cycle (already debounced and one-shot upstream).
- `AUTO` in 1: enables auto-advance after `LOOPS_PER_MODE` loops.
- `LEDr1`, `LEDr2`, `LEDr3`, `LEDr4` in 18 each: LED vectors from modes 1–4.
- `state1`, `state2`, `state3`, `state4` in 3 each: current state index of modes 1–4; 0 means the pattern's first state.
- `MODE_ON` out 4: one-hot enables driving the `MODEx_ON` inputs of the mode blocks.
- `LEDR` out 18: board LED output.
- `mode` out 2: index of the selected mode, 0–3.
- `blank` out 1: high while in BLANK.

## Operation
- FSM has two states: BLANK and ACTIVE.
- BLANK behaviour:
  - `MODE_ON` = 0000 and `LEDR` = 0.
  - `blank_cnt` counts 0 to `BLANK_CYCLES`-1.
  - On the terminal count, go to ACTIVE. This also clears the loop counter and `prev_st`.
- ACTIVE behaviour:
  - `MODE_ON` = one-hot of `mode`, and `LEDR` = `LEDr{mode+1}`.
  - `prev_st` registers the selected mode's state each cycle.
  - A loop completes when `prev_st` ≠ 0 and the current selected state = 0. Each completion increments `loop_cnt`, saturating at `LOOPS_PER_MODE`.
- Advance condition, evaluated in ACTIVE only: `BTN_NEXT`, or (`AUTO` and a loop completes with `loop_cnt` = `LOOPS_PER_MODE`-1).
  - On advance: `mode` ← `mode`+1 modulo 4 (mode 3 wraps to 0), `blank_cnt` ← 0, FSM → BLANK.
- Simultaneous button and auto-advance in the same cycle produce exactly one advance.
- `BTN_NEXT` during BLANK is ignored (not queued).
- `AUTO` deasserted: `loop_cnt` keeps counting but never triggers an advance. Asserting `AUTO` when `loop_cnt` is already saturated triggers an advance on the next loop completion.
- Reset, from any state including mid-BLANK: FSM = BLANK, `mode` = 0, `blank_cnt` = 0, `loop_cnt` = 0, `prev_st` = 0. Resulting outputs: `MODE_ON` = 0000, `LEDR` = 0, `blank` = 1.

## Timing
- `MODE_ON`, `mode` and `blank` are registered, i.e. decoded directly from FSM and `mode` flops.
- `LEDR` is a combinational mux of the registered `mode`/FSM state and the `LEDr*` inputs, so it has zero added latency relative to the mode blocks.
- Advance request sampled at edge N → `MODE_ON` = 0000 from N. The new mode's bit rises at edge N+`BLANK_CYCLES`.
- The blank gap is long enough for each mode block to see `MODEx_ON` = 0 for at least one edge, so every mode restarts at its state 0.
- After reset release, mode 0 is enabled at edge `BLANK_CYCLES`.
- Loop completion is detected in the same cycle the selected state returns to 0, because `prev_st` holds the previous value.
- The first `PULSE` of ACTIVE cannot produce a false completion, because `prev_st` was cleared to 0.

## Structure
- Shared package `led_pkg`:
  - `LED_W` = 18, `ST_W` = 3, `NUM_MODES` = 4.
  - FSM state constants `SCH_BLANK` and `SCH_ACTIVE`.
  - Mode index constants `MODE1`–`MODE4`.
- One natural sub-module: `loop_detector`.
  - Contents: `prev_st` register, wrap detect and saturating `loop_cnt`.
  - Inputs: `PULSE`, `RESET`, clear, selected state.
  - Outputs: `loop_done` (one-cycle pulse) and `loop_cnt`.
- The 4:1 LED mux and state-select mux stay inline in the top.

## Test plan
- Reset then idle with `BLANK_CYCLES`=2: `MODE_ON` = 0000 and `LEDR` = 0 for edges 0–1; `MODE_ON` = 0001 from edge 2; `LEDR` = `LEDr1` while ACTIVE.
- `BTN_NEXT` pulse in mode 3: `MODE_ON` = 0000 for 2 cycles, then 0001 with `mode` = 0 (wrap); a second `BTN_NEXT` during the blank produces no extra advance.
- `AUTO` = 1, `LOOPS_PER_MODE` = 3, `state1` driven 0→2→4→0 three times: advance on the third return to 0; `mode` goes 0→1, and no advance after only two loops.
- `AUTO` = 1 with `BTN_NEXT` asserted in the same cycle as the third loop completion: `mode` advances by exactly 1.
- `RESET` asserted mid-BLANK and again mid-ACTIVE in mode 2: next edge gives `mode` = 0, `MODE_ON` = 0000, `blank` = 1, and `loop_cnt` restarts, verified by requiring 3 fresh loops before auto-advance.
- `AUTO` = 0 for 5 loops, then `AUTO` = 1: advance occurs on the next loop completion, not immediately.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants for the LED driver: vector widths, scheduler FSM encoding and mode indices.
package led_pkg;

  localparam int unsigned LED_W     = 18;
  localparam int unsigned ST_W      = 3;
  localparam int unsigned NUM_MODES = 4;

  localparam logic [0:0] SCH_BLANK  = 1'b0;
  localparam logic [0:0] SCH_ACTIVE = 1'b1;

  localparam logic [1:0] MODE1 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd1;
  localparam logic [1:0] MODE3 = 2'd2;
  localparam logic [1:0] MODE4 = 2'd3;

  function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [1:0] m);
    return 4'b0001 << m;
  endfunction

endpackage

// File: rtl/loop_detector.sv
// Detects a pattern wrapping back to state 0 and counts completed loops, saturating at
// LOOPS_PER_MODE.
module loop_detector
  import led_pkg::*;
#(
  parameter int unsigned LOOPS_PER_MODE = 3
) (
  input  logic            PULSE,
  input  logic            RESET,
  input  logic            i_clear,
  input  logic [ST_W-1:0] i_st,
  output logic            o_loop_done,
  output logic [3:0]      o_loop_cnt
);

  logic [ST_W-1:0] r_prev_st;
  logic [3:0]      r_loop_cnt;

  // Held clear while the scheduler is blank, so the first active cycle sees prev_st = 0.
  assign o_loop_done = !i_clear && (r_prev_st != '0) && (i_st == '0);
  assign o_loop_cnt  = r_loop_cnt;

  always_ff @(posedge PULSE) begin
    if (RESET || i_clear) begin
      r_prev_st  <= '0;
      r_loop_cnt <= '0;
    end else begin
      r_prev_st <= i_st;
      if (o_loop_done && (r_loop_cnt < 4'(LOOPS_PER_MODE))) begin
        r_loop_cnt <= r_loop_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/led_mode_scheduler.sv
// Sequences the four LED pattern modes with a dark gap between them; advances on a button
// press or, with AUTO set, after LOOPS_PER_MODE completed pattern loops.
module led_mode_scheduler
  import led_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned LOOPS_PER_MODE = 3
) (
  input  logic                 PULSE,
  input  logic                 RESET,
  input  logic                 BTN_NEXT,
  input  logic                 AUTO,
  input  logic [LED_W-1:0]     LEDr1,
  input  logic [LED_W-1:0]     LEDr2,
  input  logic [LED_W-1:0]     LEDr3,
  input  logic [LED_W-1:0]     LEDr4,
  input  logic [ST_W-1:0]      state1,
  input  logic [ST_W-1:0]      state2,
  input  logic [ST_W-1:0]      state3,
  input  logic [ST_W-1:0]      state4,
  output logic [NUM_MODES-1:0] MODE_ON,
  output logic [LED_W-1:0]     LEDR,
  output logic [1:0]           mode,
  output logic                 blank
);

  logic [0:0]      r_state;
  logic [1:0]      r_mode;
  logic [3:0]      r_blank_cnt;

  logic [ST_W-1:0]  w_sel_st;
  logic [LED_W-1:0] w_sel_led;
  logic             w_active;
  logic             w_blank_term;
  logic             w_loop_done;
  logic [3:0]       w_loop_cnt;
  logic             w_advance;

  always_comb begin
    w_sel_st  = state1;
    w_sel_led = LEDr1;
    unique case (r_mode)
      MODE1: begin w_sel_st = state1; w_sel_led = LEDr1; end
      MODE2: begin w_sel_st = state2; w_sel_led = LEDr2; end
      MODE3: begin w_sel_st = state3; w_sel_led = LEDr3; end
      MODE4: begin w_sel_st = state4; w_sel_led = LEDr4; end
      default: begin w_sel_st = state1; w_sel_led = LEDr1; end
    endcase
  end

  assign w_active     = (r_state == SCH_ACTIVE);
  assign w_blank_term = (r_blank_cnt == 4'(BLANK_CYCLES - 1));

  loop_detector #(
    .LOOPS_PER_MODE (LOOPS_PER_MODE)
  ) u_loop_detector (
    .PULSE       (PULSE),
    .RESET       (RESET),
    .i_clear     (!w_active),
    .i_st        (w_sel_st),
    .o_loop_done (w_loop_done),
    .o_loop_cnt  (w_loop_cnt)
  );

  // >= rather than == so that enabling AUTO after the count saturated still fires next loop.
  assign w_advance = w_active &&
                     (BTN_NEXT ||
                      (AUTO && w_loop_done && (w_loop_cnt >= 4'(LOOPS_PER_MODE - 1))));

  always_ff @(posedge PULSE) begin
    if (RESET) begin
      r_state     <= SCH_BLANK;
      r_mode      <= MODE1;
      r_blank_cnt <= '0;
    end else if (!w_active) begin
      if (w_blank_term) begin
        r_state <= SCH_ACTIVE;
      end else begin
        r_blank_cnt <= r_blank_cnt + 4'd1;
      end
    end else if (w_advance) begin
      r_state     <= SCH_BLANK;
      r_mode      <= r_mode + 2'd1;
      r_blank_cnt <= '0;
    end
  end

  assign MODE_ON = w_active ? mode_onehot(r_mode) : '0;
  assign LEDR    = w_active ? w_sel_led : '0;
  assign mode    = r_mode;
  assign blank   = !w_active;

endmodule

// File: tb/tb_led_mode_scheduler.sv
// Directed bench for led_mode_scheduler: stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them.
module tb_led_mode_scheduler;

  logic        PULSE = 1'b0;
  logic        RESET;
  logic        BTN_NEXT;
  logic        AUTO;
  logic [17:0] led_tab [4];
  logic [2:0]  st [4];
  logic [3:0]  MODE_ON;
  logic [17:0] LEDR;
  logic [1:0]  mode;
  logic        blank;

  typedef struct {
    string       name;
    logic [3:0]  mode_on;
    logic [17:0] ledr;
    logic [1:0]  mode;
    logic        blank;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 PULSE = ~PULSE;

  led_mode_scheduler #(
    .BLANK_CYCLES   (2),
    .LOOPS_PER_MODE (3)
  ) dut (
    .PULSE    (PULSE),
    .RESET    (RESET),
    .BTN_NEXT (BTN_NEXT),
    .AUTO     (AUTO),
    .LEDr1    (led_tab[0]),
    .LEDr2    (led_tab[1]),
    .LEDr3    (led_tab[2]),
    .LEDr4    (led_tab[3]),
    .state1   (st[0]),
    .state2   (st[1]),
    .state3   (st[2]),
    .state4   (st[3]),
    .MODE_ON  (MODE_ON),
    .LEDR     (LEDR),
    .mode     (mode),
    .blank    (blank)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  always @(negedge PULSE) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, ".MODE_ON"}, 32'(MODE_ON), 32'(e.mode_on));
      cmp({e.name, ".LEDR"},    32'(LEDR),    32'(e.ledr));
      cmp({e.name, ".mode"},    32'(mode),    32'(e.mode));
      cmp({e.name, ".blank"},   32'(blank),   32'(e.blank));
    end
  end

  task automatic tick();
    @(posedge PULSE);
    #1;
  endtask

  task automatic exp_act(input string nm, input int m);
    logic [3:0] oh;
    case (m)
      0: oh = 4'b0001;
      1: oh = 4'b0010;
      2: oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    q.push_back('{nm, oh, led_tab[m], 2'(m), 1'b0});
  endtask

  task automatic exp_blank(input string nm, input int m);
    q.push_back('{nm, 4'b0000, 18'h0, 2'(m), 1'b1});
  endtask

  task automatic press(input int m_to);
    BTN_NEXT = 1'b1;
    tick(); BTN_NEXT = 1'b0; exp_blank("press_b0", m_to);
    tick(); exp_blank("press_b1", m_to);
    tick(); exp_act("press_act", m_to);
  endtask

  // One 2 -> 4 -> 0 pattern loop on mode m's state input; optional button on the wrap cycle.
  task automatic run_loop(input int m, input string nm, input logic btn_last);
    for (int i = 0; i < 3; i++) begin
      tick();
      st[m] = (i == 0) ? 3'd2 : (i == 1) ? 3'd4 : 3'd0;
      if (i == 2) BTN_NEXT = btn_last;
      exp_act(nm, m);
    end
  endtask

  task automatic adv_to(input int m_to, input string nm);
    tick(); BTN_NEXT = 1'b0; exp_blank({nm, "_b0"}, m_to);
    tick(); exp_blank({nm, "_b1"}, m_to);
    tick(); exp_act({nm, "_act"}, m_to);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    led_tab[0] = 18'h1A5A5; led_tab[1] = 18'h2B4B4;
    led_tab[2] = 18'h3C3C3; led_tab[3] = 18'h0D2D2;
    for (int i = 0; i < 4; i++) st[i] = 3'd0;
    RESET = 1'b1; BTN_NEXT = 1'b0; AUTO = 1'b0;

    // Reset then idle
    tick(); tick(); RESET = 1'b0; exp_blank("rst_edge0", 0);
    tick(); exp_blank("rst_edge1", 0);
    tick(); exp_act("rst_edge2", 0);
    tick(); exp_act("idle_m0", 0);

    // Step to mode index 3, then wrap with a second press during the gap
    press(1); press(2); press(3);
    BTN_NEXT = 1'b1;
    tick(); BTN_NEXT = 1'b1; exp_blank("wrap_b0", 0);
    tick(); BTN_NEXT = 1'b0; exp_blank("wrap_b1", 0);
    tick(); exp_act("wrap_act", 0);
    tick(); exp_act("wrap_no_extra", 0);

    // Auto advance after three loops
    AUTO = 1'b1;
    run_loop(0, "auto_l1", 1'b0);
    run_loop(0, "auto_l2", 1'b0);
    run_loop(0, "auto_l3", 1'b0);
    adv_to(1, "auto_adv");

    // Button coinciding with the third completion: one advance only
    run_loop(1, "both_l1", 1'b0);
    run_loop(1, "both_l2", 1'b0);
    run_loop(1, "both_l3", 1'b1);
    adv_to(2, "both_adv");
    tick(); exp_act("both_single", 2);

    // Reset mid-ACTIVE with two loops already counted
    run_loop(2, "pre_rst_l1", 1'b0);
    run_loop(2, "pre_rst_l2", 1'b0);
    RESET = 1'b1;
    tick(); RESET = 1'b0; exp_blank("rst_act_e0", 0);
    tick(); exp_blank("rst_act_e1", 0);
    tick(); exp_act("rst_act_e2", 0);
    run_loop(0, "fresh_l1", 1'b0);
    run_loop(0, "fresh_l2", 1'b0);
    run_loop(0, "fresh_l3", 1'b0);
    tick(); exp_blank("fresh_adv_b0", 1);

    // Reset mid-BLANK
    RESET = 1'b1;
    tick(); RESET = 1'b0; exp_blank("rst_blk_e0", 0);
    tick(); exp_blank("rst_blk_e1", 0);
    tick(); exp_act("rst_blk_e2", 0);

    // AUTO off for five loops, then on: advance at the following completion
    AUTO = 1'b0;
    for (int k = 0; k < 5; k++) run_loop(0, "noauto_l", 1'b0);
    tick(); st[0] = 3'd2; AUTO = 1'b1; exp_act("late_s2", 0);
    tick(); st[0] = 3'd4; exp_act("late_s4", 0);
    tick(); st[0] = 3'd0; exp_act("late_s0", 0);
    adv_to(1, "late_adv");

    tick();
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
